score_display: RTL and testbench

SCORE_DISPLAY -- requirements
Module: score_display

---
 rtl/score_display.sv | 115 +++++++++++
 tb/tb_score_display.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/score_display.sv
// Four-digit multiplexed seven-segment score display with per-frame snapshot,
// leading-zero blanking, level decimal point and game-over blinking.
module score_display #(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLINK_FRAMES = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] score3,
  input  logic [3:0] score2,
  input  logic [3:0] score1,
  input  logic [3:0] score0,
  input  logic       alive,
  input  logic [1:0] level,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int unsigned DW = $clog2(REFRESH_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(REFRESH_DIV - 1);
  localparam logic [7:0]    FRM_LAST = 8'(BLINK_FRAMES - 1);

  logic [DW-1:0]     div_q, div_d;
  logic [1:0]        idx_q, idx_d;
  logic [3:0][3:0]   snap_q, snap_d;
  logic [7:0]        frm_q, frm_d;
  logic              hide_q, hide_d;
  logic [3:0]        an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;

  logic              slot_end, wrap, enabled, lz;
  logic [3:0]        digit;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b0111111;
    endcase
  endfunction

  always_comb begin
    slot_end = (div_q == DIV_LAST);
    wrap     = slot_end && (idx_q == 2'd3);
    div_d    = slot_end ? '0 : div_q + 1'b1;
    idx_d    = slot_end ? idx_q + 2'd1 : idx_q;
    // Snapshot only at frame boundaries so one frame never mixes two scores.
    snap_d   = wrap ? {score3, score2, score1, score0} : snap_q;

    frm_d  = frm_q;
    hide_d = hide_q;
    if (alive) begin
      frm_d  = '0;
      hide_d = 1'b0;
    end else if (wrap) begin
      if (frm_q == FRM_LAST) begin
        frm_d  = '0;
        hide_d = ~hide_q;
      end else begin
        frm_d = frm_q + 8'd1;
      end
    end

    digit = snap_q[idx_q];
    case (idx_q)
      2'd3:    lz = (snap_q[3] == 4'd0);
      2'd2:    lz = (snap_q[3] == 4'd0) && (snap_q[2] == 4'd0);
      2'd1:    lz = (snap_q[3] == 4'd0) && (snap_q[2] == 4'd0) && (snap_q[1] == 4'd0);
      default: lz = 1'b0;
    endcase

    // First cycle of each slot is dark to avoid ghosting between digits.
    enabled = (div_q != '0) && !hide_q;
    an_d    = enabled ? ~(4'b0001 << idx_q) : 4'b1111;
    seg_d   = (!enabled || lz) ? 7'b1111111 : seg7(digit);
    dp_d    = !(enabled && (idx_q == 2'd0) && (level != 2'd0));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_q  <= '0;
      idx_q  <= '0;
      snap_q <= '0;
      frm_q  <= '0;
      hide_q <= 1'b0;
      an_q   <= 4'b1111;
      seg_q  <= 7'b1111111;
      dp_q   <= 1'b1;
    end else begin
      div_q  <= div_d;
      idx_q  <= idx_d;
      snap_q <= snap_d;
      frm_q  <= frm_d;
      hide_q <= hide_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_score_display.sv
// Bench for score_display with REFRESH_DIV=4, BLINK_FRAMES=2: a frame is 16
// cycles; expected per-cycle outputs are queued per frame and popped per edge.
module tb_score_display;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] score3, score2, score1, score0;
  logic       alive;
  logic [1:0] level;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  score_display #(.REFRESH_DIV(4), .BLINK_FRAMES(2)) dut (
    .clk(clk), .rst(rst),
    .score3(score3), .score2(score2), .score1(score1), .score0(score0),
    .alive(alive), .level(level),
    .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] s3, s2, s1, s0;
    logic [1:0] lvl;
    logic [6:0] e0, e1, e2, e3;
  } vec_t;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    bit         chk_seg;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;
  int   fnum  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Queue the 16 expected cycles of one frame from the displayed digit patterns.
  task automatic push_frame(input logic [6:0] e0, e1, e2, e3, input bit dp_on, input bit hidden);
    logic [3:0] one;
    exp_t x;
    one = 4'b0001;
    for (int k = 0; k < 16; k++) begin
      int p, d;
      p = k % 4;
      d = k / 4;
      if (p == 0 || hidden) begin
        x.an = 4'b1111; x.seg = 7'h7F; x.dp = 1'b1; x.chk_seg = 1'b0;
      end else begin
        x.an = ~(one << d);
        case (d)
          0:       x.seg = e0;
          1:       x.seg = e1;
          2:       x.seg = e2;
          default: x.seg = e3;
        endcase
        x.dp = !(d == 0 && dp_on);
        x.chk_seg = 1'b1;
      end
      sbq.push_back(x);
    end
  endtask

  task automatic pop_check(input int cnt);
    exp_t x;
    for (int i = 0; i < cnt; i++) begin
      tick();
      if (sbq.size() == 0) begin
        chk("sb_empty", 1, 0);
      end else begin
        x = sbq.pop_front();
        chk($sformatf("f%0d_c%0d_an", fnum, i), an, x.an);
        if (x.chk_seg) chk($sformatf("f%0d_c%0d_seg", fnum, i), seg, x.seg);
        chk($sformatf("f%0d_c%0d_dp", fnum, i), dp, x.dp);
      end
    end
  endtask

  task automatic run_frame(input logic [6:0] e0, e1, e2, e3, input bit hidden);
    push_frame(e0, e1, e2, e3, level != 2'd0, hidden);
    pop_check(16);
    fnum++;
  endtask

  vec_t vt[8];
  vec_t prev;

  initial begin
    vt[0] = '{4'h0, 4'h1, 4'h0, 4'h7, 2'd0, 7'h78, 7'h40, 7'h79, 7'h7F};
    vt[1] = '{4'h0, 4'h0, 4'hC, 4'h5, 2'd1, 7'h12, 7'h3F, 7'h7F, 7'h7F};
    vt[2] = '{4'h9, 4'h9, 4'h9, 4'h9, 2'd2, 7'h10, 7'h10, 7'h10, 7'h10};
    vt[3] = '{4'h1, 4'h0, 4'h0, 4'h0, 2'd3, 7'h40, 7'h40, 7'h40, 7'h79};
    vt[4] = '{4'h8, 4'h6, 4'h4, 4'h2, 2'd0, 7'h24, 7'h19, 7'h02, 7'h00};
    vt[5] = '{4'h0, 4'h3, 4'hF, 4'h0, 2'd2, 7'h40, 7'h3F, 7'h30, 7'h7F};
    vt[6] = '{4'h0, 4'h0, 4'h0, 4'h0, 2'd1, 7'h40, 7'h7F, 7'h7F, 7'h7F};
    vt[7] = '{4'hA, 4'h5, 4'h7, 4'h1, 2'd1, 7'h79, 7'h78, 7'h12, 7'h3F};
    prev  = '{4'h0, 4'h0, 4'h0, 4'h0, 2'd0, 7'h40, 7'h7F, 7'h7F, 7'h7F};

    rst = 1'b0; alive = 1'b1; level = 2'd0;
    score3 = 4'h5; score2 = 4'h5; score1 = 4'h5; score0 = 4'h5;
    repeat (3) tick();
    chk("rst_an", an, 4'b1111);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dp", dp, 1'b1);

    // Score applied during frame f is shown in frame f+1; level acts at once.
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      {score3, score2, score1, score0} = {vt[i].s3, vt[i].s2, vt[i].s1, vt[i].s0};
      level = vt[i].lvl;
      run_frame(prev.e0, prev.e1, prev.e2, prev.e3, 1'b0);
      prev = vt[i];
    end
    run_frame(prev.e0, prev.e1, prev.e2, prev.e3, 1'b0);

    // Game over: two visible frames, two dark frames, repeating.
    alive = 1'b0;
    run_frame(prev.e0, prev.e1, prev.e2, prev.e3, 1'b0);
    run_frame(prev.e0, prev.e1, prev.e2, prev.e3, 1'b0);
    run_frame(prev.e0, prev.e1, prev.e2, prev.e3, 1'b1);
    run_frame(prev.e0, prev.e1, prev.e2, prev.e3, 1'b1);
    run_frame(prev.e0, prev.e1, prev.e2, prev.e3, 1'b0);
    run_frame(prev.e0, prev.e1, prev.e2, prev.e3, 1'b0);

    // Revive part-way through a dark frame.
    push_frame(prev.e0, prev.e1, prev.e2, prev.e3, 1'b1, 1'b1);
    pop_check(5);
    sbq.delete();
    alive = 1'b1;
    tick();
    tick();
    chk("revive_an", an, 4'b1101);
    chk("revive_seg", seg, prev.e1);
    repeat (9) tick();
    fnum++;
    run_frame(prev.e0, prev.e1, prev.e2, prev.e3, 1'b0);

    // Mid-frame reset with a new score pending: snapshot restarts at zero.
    level = 2'd0;
    repeat (6) tick();
    {score3, score2, score1, score0} = 16'h9999;
    rst = 1'b0;
    tick();
    chk("midrst_an", an, 4'b1111);
    chk("midrst_seg", seg, 7'h7F);
    chk("midrst_dp", dp, 1'b1);
    rst = 1'b1;
    tick();
    chk("rel1_an", an, 4'b1111);
    tick();
    chk("rel2_an", an, 4'b1110);
    chk("rel2_seg", seg, 7'h40);
    repeat (14) tick();
    run_frame(7'h10, 7'h10, 7'h10, 7'h10, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
